// File: rtl/mult_fixed_pipe.sv
// rtl/mult_fixed_pipe.sv - two-stage multi-lane unsigned x signed fixed-point multiplier
// Optional round-half-up in stage 2 when MULT_FIXED_ROUND_EN is defined; truncation otherwise.
module mult_fixed_pipe #(
  parameter int LANES = 4,
  parameter int A_W   = 8,
  parameter int B_W   = 8,
  parameter int OUT_W = 8,
  parameter int SHIFT = 8,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*A_W-1:0]   in_a,
  input  logic [LANES*B_W-1:0]   in_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*OUT_W-1:0] out_data,
  output logic [LANES-1:0]       out_sat,
  output logic [CNT_W-1:0]       sat_cnt
);

  localparam int PW = A_W + B_W + 1;
  localparam int RW = PW + 1;
  localparam logic signed [RW-1:0] SAT_MAX = RW'((longint'(1) << (OUT_W - 1)) - 1);
  localparam logic signed [RW-1:0] SAT_MIN = RW'(-(longint'(1) << (OUT_W - 1)));

  logic                   s1_valid;
  logic                   s1_en;
  logic                   s2_en;
  logic                   accept;
  logic                   out_fire;
  logic [LANES*OUT_W-1:0] r_data;
  logic [LANES-1:0]       r_sat;

  assign s2_en    = !out_valid || out_ready;
  assign s1_en    = !s1_valid || s2_en;
  assign in_ready = s1_en && !flush;
  assign accept   = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic signed [PW-1:0]    a_ext;
    logic signed [PW-1:0]    b_ext;
    logic signed [PW-1:0]    p_next;
    logic signed [PW-1:0]    s1_p;
    logic signed [RW-1:0]    p_wide;
    logic signed [RW-1:0]    r_wide;
    logic [OUT_W-1:0]        lane_data;
    logic                    lane_sat;

    // Product is exact in PW bits, so the truncating multiply never loses information.
    assign a_ext  = {{(B_W + 1){1'b0}}, in_a[i*A_W +: A_W]};
    assign b_ext  = {{(A_W + 1){in_b[i*B_W + B_W - 1]}}, in_b[i*B_W +: B_W]};
    assign p_next = a_ext * b_ext;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_p <= '0;
      end else if (accept) begin
        s1_p <= p_next;
      end
    end

    assign p_wide = {s1_p[PW-1], s1_p};

`ifdef MULT_FIXED_ROUND_EN
    if (SHIFT > 0) begin : g_round
      localparam logic signed [RW-1:0] HALF = RW'(longint'(1) << (SHIFT - 1));
      assign r_wide = (p_wide + HALF) >>> SHIFT;
    end else begin : g_noround
      assign r_wide = p_wide;
    end
`else
    assign r_wide = p_wide >>> SHIFT;
`endif

    always_comb begin
      lane_sat  = 1'b0;
      lane_data = r_wide[OUT_W-1:0];
      if (r_wide > SAT_MAX) begin
        lane_sat  = 1'b1;
        lane_data = SAT_MAX[OUT_W-1:0];
      end else if (r_wide < SAT_MIN) begin
        lane_sat  = 1'b1;
        lane_data = SAT_MIN[OUT_W-1:0];
      end
    end

    assign r_data[i*OUT_W +: OUT_W] = lane_data;
    assign r_sat[i]                 = lane_sat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= '0;
    end else begin
      if (flush) begin
        s1_valid  <= 1'b0;
        out_valid <= 1'b0;
      end else begin
        if (s1_en) s1_valid  <= in_valid;
        if (s2_en) out_valid <= s1_valid;
      end
      // Results only move on a real stage-2 load, so held data stays put across stalls.
      if (s2_en && s1_valid && !flush) begin
        out_data <= r_data;
        out_sat  <= r_sat;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_cnt <= '0;
    end else if (out_fire && (|out_sat) && !(&sat_cnt)) begin
      sat_cnt <= sat_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_mult_fixed_pipe.sv
// tb/tb_mult_fixed_pipe.sv - directed table-driven bench for mult_fixed_pipe
module tb_mult_fixed_pipe;

`ifdef MULT_FIXED_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        flush0, iv0, ir0, ov0, or0;
  logic [31:0] a0, b0, d0;
  logic [3:0]  s0;
  logic [15:0] c0;

  logic        flush1, iv1, ir1, ov1, or1;
  logic [31:0] a1, b1, d1;
  logic [3:0]  s1;
  logic [1:0]  c1;

  mult_fixed_pipe u_def (
    .clk(clk), .rst_n(rst_n), .flush(flush0), .in_valid(iv0), .in_ready(ir0),
    .in_a(a0), .in_b(b0), .out_valid(ov0), .out_ready(or0),
    .out_data(d0), .out_sat(s0), .sat_cnt(c0)
  );

  mult_fixed_pipe #(.SHIFT(4), .CNT_W(2)) u_s4 (
    .clk(clk), .rst_n(rst_n), .flush(flush1), .in_valid(iv1), .in_ready(ir1),
    .in_a(a1), .in_b(b1), .out_valid(ov1), .out_ready(or1),
    .out_data(d1), .out_sat(s1), .sat_cnt(c1)
  );

  typedef struct {
    logic [31:0] a, b, dt, dr;
    logic [3:0]  st, sr;
  } vec_t;

  vec_t v0[3];
  vec_t v1[2];
  int errs = 0;
  int checks = 0;

  function automatic logic [31:0] p4(input int l0, input int l1, input int l2, input int l3);
    return {l3[7:0], l2[7:0], l1[7:0], l0[7:0]};
  endfunction

  function automatic logic [31:0] ed(input vec_t v);
    return RND ? v.dr : v.dt;
  endfunction

  function automatic logic [3:0] es(input vec_t v);
    return RND ? v.sr : v.st;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic lat_beat(input int k, input vec_t v, input string nm);
    @(negedge clk);
    if (k == 0) begin iv0 = 1'b1; a0 = v.a; b0 = v.b; or0 = 1'b1; end
    else        begin iv1 = 1'b1; a1 = v.a; b1 = v.b; or1 = 1'b1; end
    #1;
    chk({nm, " in_ready"}, (k == 0) ? ir0 : ir1, 1);
    @(negedge clk);
    if (k == 0) iv0 = 1'b0; else iv1 = 1'b0;
    chk({nm, " valid@1"}, (k == 0) ? ov0 : ov1, 0);
    @(negedge clk);
    chk({nm, " valid@2"}, (k == 0) ? ov0 : ov1, 1);
    chk({nm, " data"}, (k == 0) ? d0 : d1, ed(v));
    chk({nm, " sat"}, (k == 0) ? s0 : s1, es(v));
  endtask

  initial begin
    int sent, recv, occ;
    logic fire_in, fire_out, prev_hold;
    logic [31:0] hd;

    v0[0] = '{a:p4(255,255,0,128), b:p4(127,-128,-128,64),
              dt:p4(126,-128,0,32), dr:p4(127,-127,0,32), st:4'b0, sr:4'b0};
    v0[1] = '{a:p4(1,255,16,100), b:p4(-1,0,-16,-3),
              dt:p4(-1,0,-1,-2), dr:p4(0,0,-1,-1), st:4'b0, sr:4'b0};
    v0[2] = '{a:p4(200,255,3,128), b:p4(100,-1,127,-128),
              dt:p4(78,-1,1,-64), dr:p4(78,-1,1,-64), st:4'b0, sr:4'b0};
    v1[0] = '{a:p4(200,200,16,0), b:p4(100,-100,5,-128),
              dt:p4(127,-128,5,0), dr:p4(127,-128,5,0), st:4'b0011, sr:4'b0011};
    v1[1] = '{a:p4(20,32,1,100), b:p4(50,-64,-1,10),
              dt:p4(62,-128,-1,62), dr:p4(63,-128,0,63), st:4'b0, sr:4'b0};

    rst_n = 1'b0;
    flush0 = 1'b0; iv0 = 1'b0; or0 = 1'b0; a0 = '0; b0 = '0;
    flush1 = 1'b0; iv1 = 1'b0; or1 = 1'b0; a1 = '0; b1 = '0;
    #12;
    chk("reset out_valid", {ov1, ov0}, 0);
    chk("reset out_data", {d1, d0}, 0);
    chk("reset out_sat", {s1, s0}, 0);
    chk("reset sat_cnt", {c1, c0}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("in_ready after reset", {ir1, ir0}, 2'b11);

    for (int i = 0; i < 3; i++) lat_beat(0, v0[i], $sformatf("def vec%0d", i));

    lat_beat(1, v1[0], "s4 sat");
    @(negedge clk);
    chk("sat_cnt first", c1, 1);
    lat_beat(1, v1[1], "s4 nosat");
    @(negedge clk);
    chk("sat_cnt nosat", c1, 1);
    for (int i = 0; i < 4; i++) begin
      lat_beat(1, v1[0], $sformatf("s4 sat%0d", i));
      @(negedge clk);
      chk($sformatf("sat_cnt step%0d", i), c1, (i == 0) ? 2 : 3);
    end
    or1 = 1'b0;

    sent = 0; recv = 0; occ = 0; prev_hold = 1'b0; hd = '0;
    for (int cyc = 0; cyc < 300 && recv < 10; cyc++) begin
      @(negedge clk);
      or0 = 1'($urandom_range(0, 1));
      iv0 = (sent < 10);
      if (sent < 10) begin a0 = v0[sent % 3].a; b0 = v0[sent % 3].b; end
      #1;
      if (prev_hold) begin
        chk("stall valid", ov0, 1);
        chk("stall data", d0, hd);
      end
      chk("stream in_ready", ir0, !(occ == 2 && !or0));
      fire_in  = iv0 && ir0;
      fire_out = ov0 && or0;
      if (fire_out) begin
        chk($sformatf("stream beat%0d", recv), d0, ed(v0[recv % 3]));
        recv++;
      end
      prev_hold = ov0 && !or0;
      hd = d0;
      @(posedge clk);
      occ = occ + int'(fire_in) - int'(fire_out);
      sent = sent + int'(fire_in);
    end
    chk("stream count", recv, 10);

    @(negedge clk);
    iv0 = 1'b0; or0 = 1'b0;
    @(negedge clk);
    iv0 = 1'b1; a0 = v0[0].a; b0 = v0[0].b;
    @(negedge clk);
    a0 = v0[1].a; b0 = v0[1].b;
    @(negedge clk);
    chk("two in flight", ov0, 1);
    flush0 = 1'b1; a0 = v0[2].a; b0 = v0[2].b;
    #1;
    chk("flush in_ready", ir0, 0);
    @(negedge clk);
    flush0 = 1'b0; iv0 = 1'b0; or0 = 1'b1;
    chk("flush clears", ov0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("no stale %0d", i), ov0, 0);
    end
    lat_beat(0, v0[2], "post flush");

    @(negedge clk);
    or1 = 1'b0; iv1 = 1'b1; a1 = v1[0].a; b1 = v1[0].b;
    or0 = 1'b0; iv0 = 1'b1; a0 = v0[0].a; b0 = v0[0].b;
    @(negedge clk);
    @(negedge clk);
    iv0 = 1'b0; iv1 = 1'b0;
    chk("pre-reset valid", {ov1, ov0}, 2'b11);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset valid", {ov1, ov0}, 0);
    chk("async reset data", {d1, d0}, 0);
    chk("async reset sat", {s1, s0}, 0);
    chk("async reset cnt", {c1, c0}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("in_ready post reset", {ir1, ir0}, 2'b11);
    lat_beat(1, v1[1], "after reset");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/mult_fixed_pipe.md
Name: mult_fixed_pipe

Overview:
Parametrised, pipelined, multi-lane fixed-point multiplier. It is the successor to the single-cycle combinational multiplier in the PE datapath.
- Each lane multiplies an unsigned feature value by a signed weight, then shifts, optionally rounds, and saturates to a signed output.
- Two register stages with valid/ready backpressure, so it drops into streaming PE arrays.
- Also reports per-lane saturation and keeps a saturation event counter.

Parameters:
LANES, 4, number of independent multiplier lanes
A_W, 8, width of unsigned operand A per lane (default format (8,7))
B_W, 8, width of signed operand B per lane (default format (8,6))
OUT_W, 8, width of signed result per lane (default format (8,5))
SHIFT, 8, right-shift applied to the full product; must be < A_W+B_W
CNT_W, 16, width of saturation event counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous pipeline clear; drops all in-flight data
in_valid  in  1  input beat valid
in_ready  out  1  block can accept an input beat
in_a  in  LANES*A_W  unsigned operands; lane i at [i*A_W +: A_W]
in_b  in  LANES*B_W  signed operands; lane i at [i*B_W +: B_W]
out_valid  out  1  result beat valid
out_ready  in  1  downstream accepts result
out_data  out  LANES*OUT_W  signed results; lane i at [i*OUT_W +: OUT_W]
out_sat  out  LANES  lane i result was clipped
sat_cnt  out  CNT_W  number of accepted output beats with any out_sat bit set

Behaviour:
Reset:
- Reset is asynchronous and active-low on rst_n, with one clock clk.
- While rst_n=0: all valid bits, out_data, out_sat and sat_cnt are 0.

Arithmetic (per lane):
- A is zero-extended, B is sign-extended.
- Full product P is signed, A_W+B_W+1 bits, exact (no overflow).
- Stage 1 registers P and s1_valid.
- Stage 2 computes R = P >>> SHIFT (arithmetic, floor), saturates R to [-2^(OUT_W-1), 2^(OUT_W-1)-1], and sets out_sat when clipped.
- Stage 2 registers the result into out_data/out_sat with out_valid.

Handshake:
- Input is accepted on in_valid && in_ready. Output is consumed on out_valid && out_ready.
- s2_en = !out_valid || out_ready.
- s1_en = !s1_valid || s2_en.
- in_ready = s1_en (combinational; no path from in_valid to in_ready).
- Latency: 2 cycles from acceptance to out_valid when unstalled.
- Throughput: 1 beat/cycle with out_ready held high.
- Stall: out_data/out_sat hold stable while out_valid && !out_ready. A beat is never lost or duplicated. Stage 1 fills, then in_ready drops.
- Data registers update only on their stage enable; valid bits follow the enables.

Flush:
- On the next edge, clears s1_valid and out_valid.
- in_ready is forced 0 during the flush cycle; any input that cycle is ignored.
- sat_cnt is not cleared.

sat_cnt:
- Increments by 1 on each output handshake with |out_sat.
- Sticks at all-ones; it does not wrap.
- Cleared only by rst_n.

Boundary cases:
- Reset mid-stream drops all data immediately; in_ready goes 1 after reset releases.
- Simultaneous flush and output handshake: the beat counts as consumed and sat_cnt may increment, but the pipeline is emptied.
- A=0 or B=0 gives a result of 0 with out_sat=0.

Optional Feature:
Macro MULT_FIXED_ROUND_EN.
- Defined: stage 2 uses round-half-up, R = (P + 2^(SHIFT-1)) >>> SHIFT, before saturation. The add is performed in one extra bit so it cannot overflow. SHIFT=0 bypasses rounding.
- Undefined: truncation (floor), as specified above.
- Latency and handshake are unchanged in both cases.

Test Plan:
- Defaults, lane0 A=255, B=127, out_ready=1 -> out_valid 2 cycles after acceptance. out_data=126 (with ROUND_EN: 127), out_sat=0.
- Defaults, A=255, B=-128 -> -128 (with ROUND_EN: -127), out_sat=0.
- SHIFT=4, lane0 A=200 B=100 and lane1 A=200 B=-100 -> lane0 127, lane1 -128, out_sat=0b0011. sat_cnt increments by 1 on the handshake.
- Stream 10 beats with out_ready toggling randomly -> all 10 results in order, none lost or duplicated. out_data is stable during stalls. in_ready=0 only when both stages are full and out_ready=0.
- Two beats in flight, assert flush one cycle -> out_valid=0 next cycle, no stale output ever appears. The next input produces correct output with 2-cycle latency.
- CNT_W=2, 5 saturating beats -> sat_cnt reads 1, 2, 3, 3, 3. Assert rst_n=0 mid-stream -> all outputs 0 immediately, without waiting for a clock edge.
